// File: rtl/deal_pkg.sv
// Shared types and constants for the card deal arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package deal_pkg;

  localparam int unsigned CARD_W     = 4;
  localparam int unsigned DEAL_CARDS = 4;

  typedef logic [CARD_W-1:0] card_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } arb_state_t;

  typedef enum logic {
    PLAYER,
    DEALER
  } target_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter between player and dealer hit requests.
// Combinational; grant is one-hot {dealer, player}.
module rr_arbiter_2
  import deal_pkg::*;
(
  input  logic       i_playerReq,
  input  logic       i_dealerReq,
  input  logic       i_playerMask,
  input  logic       i_dealerMask,
  input  target_t    i_lastServed,
  output logic [1:0] o_grant_c
);

  logic w_p;
  logic w_d;

  assign w_p = i_playerReq & ~i_playerMask;
  assign w_d = i_dealerReq & ~i_dealerMask;

  // On contention, favour whichever side was not served last.
  always_comb begin
    o_grant_c = 2'b00;
    if (w_p && w_d) begin
      o_grant_c = (i_lastServed == PLAYER) ? 2'b10 : 2'b01;
    end else begin
      o_grant_c = {w_d, w_p};
    end
  end

endmodule

// File: rtl/card_deal_arbiter.sv
// Owns the card deck: runs the D,P,D,P opening deal, then serialises hit
// requests, routing each drawn card to one hand with a single-cycle strobe.
module card_deal_arbiter #(
  parameter int unsigned CARD_W       = 4,
  parameter int unsigned DECK_LATENCY = 1,
  parameter int unsigned MAX_CARDS    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_startDeal,
  input  logic              i_playerReq,
  input  logic              i_dealerReq,
  input  logic [2:0]        i_playerCount,
  input  logic [2:0]        i_dealerCount,
  input  logic [CARD_W-1:0] i_deckCard,
  output logic              o_deckDraw,
  output logic [CARD_W-1:0] o_card,
  output logic              o_playerLoad,
  output logic              o_dealerLoad,
  output logic              o_playerGrant,
  output logic              o_dealerGrant,
  output logic              o_dealDone,
  output logic              o_busy
);

  import deal_pkg::*;

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STEP_W = 2;

  arb_state_t        r_state;
  target_t           r_target;
  target_t           r_lastServed;
  logic [STEP_W-1:0] r_dealStep;
  logic              r_dealActive;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CARD_W-1:0] r_card;
  logic              r_deckDraw;
  logic              r_playerLoad;
  logic              r_dealerLoad;
  logic              r_playerGrant;
  logic              r_dealerGrant;
  logic              r_dealDone;
  logic              r_busy;

  logic              w_playerMask;
  logic              w_dealerMask;
  logic [1:0]        w_grant;

  // Requests only count once the opening deal has finished.
  assign w_playerMask = (i_playerCount == CNT_W'(MAX_CARDS));
  assign w_dealerMask = (i_dealerCount == CNT_W'(MAX_CARDS));

  rr_arbiter_2 u_rr (
    .i_playerReq  (i_playerReq & r_dealDone),
    .i_dealerReq  (i_dealerReq & r_dealDone),
    .i_playerMask (w_playerMask),
    .i_dealerMask (w_dealerMask),
    .i_lastServed (r_lastServed),
    .o_grant_c    (w_grant)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_target      <= DEALER;
      r_lastServed  <= DEALER;
      r_dealStep    <= '0;
      r_dealActive  <= 1'b0;
      r_waitCnt     <= '0;
      r_card        <= '0;
      r_deckDraw    <= 1'b0;
      r_playerLoad  <= 1'b0;
      r_dealerLoad  <= 1'b0;
      r_playerGrant <= 1'b0;
      r_dealerGrant <= 1'b0;
      r_dealDone    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_deckDraw    <= 1'b0;
      r_playerLoad  <= 1'b0;
      r_dealerLoad  <= 1'b0;
      r_playerGrant <= 1'b0;
      r_dealerGrant <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_startDeal) begin
            r_dealDone   <= 1'b0;
            r_dealStep   <= '0;
            r_dealActive <= 1'b1;
            r_target     <= DEALER;
            r_state      <= S_ISSUE;
            r_deckDraw   <= 1'b1;
            r_busy       <= 1'b1;
          end else if (r_dealActive) begin
            r_target   <= r_dealStep[0] ? PLAYER : DEALER;
            r_state    <= S_ISSUE;
            r_deckDraw <= 1'b1;
            r_busy     <= 1'b1;
          end else if (|w_grant) begin
            r_target   <= w_grant[1] ? DEALER : PLAYER;
            r_state    <= S_ISSUE;
            r_deckDraw <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_waitCnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // Capture on the last latency cycle, then strobe the target hand.
          if (r_waitCnt == WAIT_W'(DECK_LATENCY - 1)) begin
            r_card        <= i_deckCard;
            r_playerLoad  <= (r_target == PLAYER);
            r_dealerLoad  <= (r_target == DEALER);
            r_playerGrant <= (r_target == PLAYER) && !r_dealActive;
            r_dealerGrant <= (r_target == DEALER) && !r_dealActive;
            r_waitCnt     <= '0;
            r_state       <= S_DELIVER;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        S_DELIVER: begin
          if (r_dealActive) begin
            if (r_dealStep == STEP_W'(DEAL_CARDS - 1)) begin
              r_dealActive <= 1'b0;
              r_dealDone   <= 1'b1;
              r_lastServed <= PLAYER;
              r_dealStep   <= '0;
            end else begin
              r_dealStep <= r_dealStep + STEP_W'(1);
            end
          end else begin
            r_lastServed <= r_target;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_deckDraw    = r_deckDraw;
  assign o_card        = r_card;
  assign o_playerLoad  = r_playerLoad;
  assign o_dealerLoad  = r_dealerLoad;
  assign o_playerGrant = r_playerGrant;
  assign o_dealerGrant = r_dealerGrant;
  assign o_dealDone    = r_dealDone;
  assign o_busy        = r_busy;

endmodule

// File: doc/card_deal_arbiter.md
Name: card_deal_arbiter

Overview:
- Sole owner of the shared card deck; serialises card draws between the player hand and the dealer hand.
- Runs the automatic opening deal, then services hit requests one at a time.
- Routes each drawn card to exactly one hand with a one-cycle load strobe, so a card is never loaded before the deck has produced it.
- Sits between the game FSM, the two hand controllers and the card deck.

Parameters:
- CARD_W, 4, width of one card code.
- DECK_LATENCY, 1, cycles from the o_deckDraw pulse to a valid i_deckCard (legal range 1..7).
- MAX_CARDS, 5, hand capacity; a hand at this count gets no more cards.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_startDeal  in  1  pulse: begin the 4-card opening deal.
- i_playerReq  in  1  level: player hit request.
- i_dealerReq  in  1  level: dealer hit request.
- i_playerCount  in  3  current player card count.
- i_dealerCount  in  3  current dealer card count.
- i_deckCard  in  CARD_W  card from the deck, valid DECK_LATENCY cycles after o_deckDraw.
- o_deckDraw  out  1  one-cycle draw pulse to the deck.
- o_card  out  CARD_W  registered card presented to both hands.
- o_playerLoad  out  1  one-cycle load strobe to the player hand.
- o_dealerLoad  out  1  one-cycle load strobe to the dealer hand.
- o_playerGrant  out  1  one-cycle pulse: player request served; equals o_playerLoad outside the opening deal.
- o_dealerGrant  out  1  one-cycle pulse: dealer request served.
- o_dealDone  out  1  level: opening deal complete.
- o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset, asynchronous: state S_IDLE; all outputs 0; o_card 0; dealStep 0; waitCnt 0; lastServed = DEALER.
- FSM states:
  - S_IDLE: accepts new work.
  - S_ISSUE: o_deckDraw = 1 for exactly this cycle.
  - S_WAIT: waitCnt counts DECK_LATENCY cycles; i_deckCard is captured into o_card on the last one.
  - S_DELIVER: exactly one load strobe plus the matching grant for one cycle; o_card holds until the next capture.
- S_IDLE priority, highest first:
  - i_startDeal: clears o_dealDone, sets dealStep = 0, target = DEALER, goes to S_ISSUE.
  - dealStep 1..3 pending (opening deal in progress): target = DEALER if dealStep is even, else PLAYER; goes to S_ISSUE.
  - o_dealDone = 1 and an unmasked request: arbitrate, latch target, go to S_ISSUE.
  - Otherwise stay in S_IDLE.
- Masking:
  - A request is masked while its count equals MAX_CARDS.
  - Every request is ignored while o_dealDone = 0 (before or during the opening deal).
- Arbitration: two-way round robin. When both requests are unmasked, grant the one not equal to lastServed. lastServed updates in S_DELIVER.
- Opening deal order is D, P, D, P. A grant does not pulse during the opening deal; only load strobes do.
- After the 4th deliver: o_dealDone = 1, lastServed = PLAYER.
- Latency: with the request sampled in S_IDLE at cycle 0:
  - draw at cycle 1
  - capture at cycle 1+DECK_LATENCY
  - load/grant at cycle 2+DECK_LATENCY
  - back in S_IDLE at cycle 3+DECK_LATENCY
  - One card per 3+DECK_LATENCY cycles at most.
- Request handshake:
  - Requests are sampled only in S_IDLE.
  - The requester drops its request in the grant cycle.
  - A request still high in the following S_IDLE counts as a new hit.
- i_startDeal while o_busy = 1 is ignored and not queued.
- i_startDeal in S_IDLE after o_dealDone = 1 restarts the opening deal. Clearing the hands is the game FSM's job.
- Counts are sampled combinationally in S_IDLE only. A count change during S_ISSUE, S_WAIT or S_DELIVER does not abort the transaction.
- Reset asserted mid-transaction: no strobe completes, the pending card is discarded, outputs are 0 immediately.
- o_playerLoad and o_dealerLoad are never high in the same cycle; o_deckDraw is never high outside S_ISSUE.

Decomposition:
- Package deal_pkg:
  - card_t (logic [CARD_W-1:0])
  - arb_state_t enum {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER}
  - target_t enum {PLAYER, DEALER}
  - DEAL_CARDS = 4
- Sub-module rr_arbiter_2: two requests, masks, lastServed in; one-hot grant out; combinational.
- Sequencing and datapath stay in card_deal_arbiter.

Test Plan:
- Reset, then i_startDeal pulse, DECK_LATENCY = 1, deck returns 3, 7, 10, 2:
  - dealer loads at cycles 3 and 11, player loads at cycles 7 and 15, each with o_card equal to the captured value
  - o_dealDone = 1 from cycle 16
  - no grant pulses.
- After the deal, player holds i_playerReq, deck returns 9:
  - o_deckDraw 1 cycle later
  - o_playerLoad and o_playerGrant with o_card = 9 at +3
  - o_busy low at +4.
- Both requests rise together after the deal (lastServed = PLAYER):
  - dealer served first, then player on the next pass
  - never both strobes in one cycle.
- i_playerCount = 5 with i_playerReq = 1 and i_dealerReq = 0:
  - no o_deckDraw for 20 cycles; o_busy stays 0.
- i_reset raised in S_WAIT of a player hit:
  - all outputs 0 in the same cycle
  - no o_playerLoad afterwards
  - o_dealDone = 0; state S_IDLE.
- i_startDeal pulsed during S_WAIT of a hit:
  - the hit completes normally
  - no restart; o_dealDone stays 1.
